// File: rtl/tx_pulse_fifo_pkg.sv
// Shared sizing helpers for the transmit pulse FIFO.
// Pointer widths are derived from DEPTH via clog2.
package tx_pulse_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic bit depth_ok(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  localparam int DEF_ADDR_W = clog2(DEF_DEPTH);

  typedef logic [DEF_ADDR_W:0] ptr_t;

endpackage

// File: rtl/tx_pulse_fifo_mem.sv
// Register-array storage: synchronous write, asynchronous read.
// No reset; contents are only observable through a non-empty head.
module tx_pulse_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tx_pulse_fifo.sv
// Byte buffer between pulse generator and transmitter.
// Head is always presented; pops come from single-cycle pulses.
module tx_pulse_fifo
  import tx_pulse_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                   i_CLK,
  input  logic                   i_RST,
  input  logic                   i_wr_en,
  input  logic [DATA_WIDTH-1:0]  i_wr_data,
  input  logic                   i_rd_inc,
  output logic [DATA_WIDTH-1:0]  o_rd_data,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [clog2(DEPTH):0]  o_count,
  output logic                   o_ovf_err,
  output logic                   o_udf_err
);

  localparam int ADDR_W = clog2(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("tx_pulse_fifo: DEPTH must be a power of two >= 2");
  end

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;

  logic            empty;
  logic            full;
  logic            wr_acc;
  logic            rd_acc;
  logic [DATA_WIDTH-1:0] head;

  // Flags come only from registered pointers.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0])
               & (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

  assign wr_acc = i_wr_en & ~full;
  assign rd_acc = i_rd_inc & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q | (i_wr_en & full);
    udf_d    = udf_q | (i_rd_inc & empty);
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  tx_pulse_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk_i   (i_CLK),
    .we_i    (wr_acc & ~i_RST),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (i_wr_data),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (head)
  );

  assign o_rd_data = empty ? '0 : head;
  assign o_empty   = empty;
  assign o_full    = full;
  assign o_count   = wr_ptr_q - rd_ptr_q;
  assign o_ovf_err = ovf_q;
  assign o_udf_err = udf_q;

endmodule

// File: tb/tb_tx_pulse_fifo.sv
// Directed bench for tx_pulse_fifo with a queue scoreboard.
// Every cycle is checked against a reference queue model.
module tb_tx_pulse_fifo;

  localparam int DW = 8;
  localparam int DP = 8;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_inc;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          full;
  logic [3:0]    count;
  logic          ovf;
  logic          udf;

  int tests;
  int fails;

  logic [DW-1:0] q[$];
  logic          m_ovf;
  logic          m_udf;

  tx_pulse_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .i_CLK     (clk),
    .i_RST     (rst),
    .i_wr_en   (wr_en),
    .i_wr_data (wr_data),
    .i_rd_inc  (rd_inc),
    .o_rd_data (rd_data),
    .o_empty   (empty),
    .o_full    (full),
    .o_count   (count),
    .o_ovf_err (ovf),
    .o_udf_err (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_chk(input string tag);
    logic [DW-1:0] h;
    h = (q.size() != 0) ? q[0] : '0;
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".head"},  32'(rd_data), 32'(h));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".full"},  32'(full), 32'(q.size() == DP));
    chk({tag, ".ovf"},   32'(ovf), 32'(m_ovf));
    chk({tag, ".udf"},   32'(udf), 32'(m_udf));
  endtask

  // One clock: drive, update model from pre-edge state, check after edge.
  task automatic cyc(input logic r, input logic w,
                     input logic [DW-1:0] d, input logic p,
                     input string tag);
    bit mf, me;
    rst     = r;
    wr_en   = w;
    wr_data = d;
    rd_inc  = p;
    mf = (q.size() == DP);
    me = (q.size() == 0);
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (p && !me) void'(q.pop_front());
      if (w && !mf) q.push_back(d);
      if (w && mf) m_ovf = 1'b1;
      if (p && me) m_udf = 1'b1;
    end
    rst    = 1'b0;
    wr_en  = 1'b0;
    rd_inc = 1'b0;
    model_chk(tag);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    rst = 1'b1;
    wr_en = 1'b0;
    wr_data = '0;
    rd_inc = 1'b0;

    cyc(1, 0, 8'h00, 0, "rst0");
    cyc(1, 0, 8'h00, 0, "rst1");
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.data",  32'(rd_data), 32'd0);

    for (int i = 1; i <= 8; i++)
      cyc(0, 1, 8'(8'hA0 + i), 0, "fill");
    chk("fill.full",  32'(full), 32'd1);
    chk("fill.count", 32'(count), 32'd8);
    chk("fill.head",  32'(rd_data), 32'hA1);

    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 8'h00, 1, "drain");
      if (i < 7) chk("drain.step", 32'(rd_data), 32'(8'hA2 + i));
      cyc(0, 0, 8'h00, 0, "idle");
    end
    chk("drain.empty", 32'(empty), 32'd1);
    chk("drain.data",  32'(rd_data), 32'd0);
    chk("drain.udf",   32'(udf), 32'd0);

    for (int i = 0; i < 8; i++)
      cyc(0, 1, 8'(8'hB0 + i), 0, "refill");
    cyc(0, 1, 8'hFF, 0, "ovf");
    chk("ovf.flag",  32'(ovf), 32'd1);
    chk("ovf.count", 32'(count), 32'd8);
    chk("ovf.head",  32'(rd_data), 32'hB0);
    cyc(0, 1, 8'hEE, 1, "ovf_both");
    chk("ovfb.count", 32'(count), 32'd7);
    chk("ovfb.head",  32'(rd_data), 32'hB1);
    chk("ovfb.flag",  32'(ovf), 32'd1);

    for (int i = 0; i < 7; i++)
      cyc(0, 0, 8'h00, 1, "drain2");
    cyc(0, 1, 8'h5C, 1, "udf_both");
    chk("udf.flag",  32'(udf), 32'd1);
    chk("udf.count", 32'(count), 32'd1);
    chk("udf.head",  32'(rd_data), 32'h5C);

    cyc(1, 0, 8'h00, 0, "rst2");
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 8'(8'h10 + i), 0, "pre");
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 8'(8'hC0 + i), 1, "wrap");
      chk("wrap.count", 32'(count), 32'd3);
    end
    chk("wrap.ovf", 32'(ovf), 32'd0);
    chk("wrap.udf", 32'(udf), 32'd0);
    chk("wrap.head", 32'(rd_data), 32'hD1);

    for (int i = 0; i < 3; i++)
      cyc(0, 0, 8'h00, 1, "empty3");
    cyc(0, 0, 8'h00, 1, "set_udf");
    for (int i = 0; i < 5; i++)
      cyc(0, 1, 8'(8'h30 + i), 0, "load5");
    chk("mid.pre_count", 32'(count), 32'd5);
    chk("mid.pre_udf",   32'(udf), 32'd1);
    cyc(1, 1, 8'h99, 1, "mid_rst");
    chk("mid.count", 32'(count), 32'd0);
    chk("mid.empty", 32'(empty), 32'd1);
    chk("mid.ovf",   32'(ovf), 32'd0);
    chk("mid.udf",   32'(udf), 32'd0);
    cyc(0, 1, 8'h77, 0, "post");
    chk("post.head", 32'(rd_data), 32'h77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
